// File: rtl/input_vc_controller_pipe_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the pipelined router input-VC controller:
//   - default router dimensions (ports, VCs, flit width, destination width)
//   - flit type encoding and the width of the type field at the flit MSBs
//   - controller FSM state encoding
//   - small helpers that classify a flit type
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int N_DEFAULT    = 5;
  localparam int V_DEFAULT    = 4;
  localparam int DW_DEFAULT   = 34;
  localparam int DSTW_DEFAULT = 8;

  // The flit type occupies the TYPE_W most significant bits of the flit.
  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VA     = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_UNUSED = 2'd3
  } state_e;

  // A flit that opens a packet.
  function automatic logic is_head(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  // A flit that closes a packet.
  function automatic logic is_tail(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/input_vc_controller_pipe_if.sv
// -----------------------------------------------------------------------------
// input_vc_controller_pipe_if
// Bundles every non-clock/reset signal of one input-VC controller: the FIFO
// head and pop, the RC request/result, the VA and SA handshakes, the
// allocated output port/VC, the output-VC ready vector, error pulse and state.
// Modports:
//   slave  - the controller's view (consumes FIFO/RC/allocator inputs)
//   master - the environment's view (FIFO, RC unit, allocators)
// -----------------------------------------------------------------------------
interface input_vc_controller_pipe_if
  import noc_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int V    = V_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int DSTW = DSTW_DEFAULT
);

  logic [DW-1:0]   data;
  logic            valid;
  logic            pop;
  logic [DSTW-1:0] dst;
  logic [N-1:0]    rcPort;
  logic [V-1:0]    rcVC;
  logic            reqVA;
  logic [N-1:0]    reqVAPort;
  logic [V-1:0]    reqVAVC;
  logic            vaGrant;
  logic [V-1:0]    vaVC;
  logic [N-1:0]    reqSA;
  logic            saGrant;
  logic [N-1:0]    outPort;
  logic [V-1:0]    outVC;
  logic [N*V-1:0]  readyVC_all;
  logic            err;
  logic [1:0]      state;

  modport slave (
    input  data, valid, rcPort, rcVC, vaGrant, vaVC, saGrant, readyVC_all,
    output pop, dst, reqVA, reqVAPort, reqVAVC, reqSA, outPort, outVC, err, state
  );

  modport master (
    output data, valid, rcPort, rcVC, vaGrant, vaVC, saGrant, readyVC_all,
    input  pop, dst, reqVA, reqVAPort, reqVAVC, reqSA, outPort, outVC, err, state
  );

endinterface

// File: rtl/input_vc_controller_pipe_onehot_to_bin.sv
// -----------------------------------------------------------------------------
// onehot_to_bin
// Converts a W-bit one-hot vector into its binary index.
// Ports:
//   onehot - input, W bits
//   idx    - output, $clog2(W) bits; 0 for an all-zero or multi-hot input
// -----------------------------------------------------------------------------
module onehot_to_bin #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] idx_acc_s;
  logic          is_onehot_s;

  // OR together the positions of all set bits; only meaningful when one-hot.
  always_comb begin
    idx_acc_s = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) begin
        idx_acc_s = idx_acc_s | IW'(i);
      end else begin
        idx_acc_s = idx_acc_s;
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign is_onehot_s = (|onehot) && ((onehot & (onehot - W'(1))) == '0);
  assign idx         = is_onehot_s ? idx_acc_s : '0;

endmodule

// File: rtl/input_vc_controller_pipe.sv
// -----------------------------------------------------------------------------
// input_vc_controller_pipe
// Per-input-VC controller of the pipelined router. Walks one virtual channel
// through head latch (IDLE), VC allocation (VA) and switch allocation
// (ACTIVE), remembers the allocated output port/VC for the whole packet and
// pops the input FIFO when a flit wins the switch.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - slave modport of input_vc_controller_pipe_if (FIFO head/pop, RC,
//          VA/SA handshakes, outPort/outVC, readyVC_all, err, state)
// -----------------------------------------------------------------------------
module input_vc_controller_pipe
  import noc_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int V    = V_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int DSTW = DSTW_DEFAULT
) (
  input logic                      clk,
  input logic                      rstn,
  input_vc_controller_pipe_if.slave bus
);

  localparam int PIW  = (N > 1) ? $clog2(N) : 1;
  localparam int VIW  = (V > 1) ? $clog2(V) : 1;
  localparam int SELW = (N * V > 1) ? $clog2(N * V) : 1;

  state_e       state_r, state_nxt_s;
  logic [N-1:0] port_r;
  logic [V-1:0] vc_mask_r;
  logic [N-1:0] out_port_r;
  logic [V-1:0] out_vc_r;
  // Set on entry to ACTIVE: the packet's own head flit has not been popped yet.
  logic         head_pending_r;

  flit_type_e    flit_type_s;
  logic [PIW-1:0] port_idx_s;
  logic [VIW-1:0] vc_idx_s;
  logic [SELW-1:0] sel_s;
  logic          rdy_s;

  logic          latch_head_s;
  logic          load_out_s;
  logic          clear_out_s;
  logic          pop_s;
  logic          err_s;
  logic          req_va_s;
  logic [N-1:0]  req_sa_s;

  assign flit_type_s = flit_type_e'(bus.data[DW-1:DW-TYPE_W]);

  onehot_to_bin #(.W(N), .IW(PIW)) u_port_idx (
    .onehot (out_port_r),
    .idx    (port_idx_s)
  );

  onehot_to_bin #(.W(V), .IW(VIW)) u_vc_idx (
    .onehot (out_vc_r),
    .idx    (vc_idx_s)
  );

  // Ready bit of the allocated output VC: bit port*V + vc.
  assign sel_s = SELW'(port_idx_s) * SELW'(V) + SELW'(vc_idx_s);
  assign rdy_s = bus.readyVC_all[sel_s];

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s  = state_r;
    latch_head_s = 1'b0;
    load_out_s   = 1'b0;
    clear_out_s  = 1'b0;
    pop_s        = 1'b0;
    err_s        = 1'b0;
    req_va_s     = 1'b0;
    req_sa_s     = '0;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid) begin
          if (is_head(flit_type_s)) begin
            latch_head_s = 1'b1;
            state_nxt_s  = ST_VA;
          end else begin
            // Orphan body/tail: drop it and flag the protocol error.
            err_s = 1'b1;
            pop_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_VA: begin
        req_va_s = 1'b1;
        if (bus.vaGrant) begin
          load_out_s  = 1'b1;
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_VA;
        end
      end
      ST_ACTIVE: begin
        if (bus.valid && rdy_s) begin
          req_sa_s = out_port_r;
        end else begin
          req_sa_s = '0;
        end
        if (bus.saGrant && (|req_sa_s)) begin
          pop_s = 1'b1;
          // Only a head after the packet's own head is a protocol error.
          if ((flit_type_s == FLIT_HEAD) && !head_pending_r) begin
            err_s = 1'b1;
          end else begin
            err_s = 1'b0;
          end
          if (is_tail(flit_type_s)) begin
            clear_out_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched RC result and allocated output port/VC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r        <= ST_IDLE;
      port_r         <= '0;
      vc_mask_r      <= '0;
      out_port_r     <= '0;
      out_vc_r       <= '0;
      head_pending_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (latch_head_s) begin
        port_r    <= bus.rcPort;
        vc_mask_r <= bus.rcVC;
      end
      if (load_out_s) begin
        out_port_r     <= port_r;
        out_vc_r       <= bus.vaVC;
        head_pending_r <= 1'b1;
      end else if (clear_out_s) begin
        out_port_r     <= '0;
        out_vc_r       <= '0;
        head_pending_r <= 1'b0;
      end else if (pop_s) begin
        head_pending_r <= 1'b0;
      end
    end
  end

  assign bus.dst       = bus.data[DSTW-1:0];
  assign bus.pop       = pop_s;
  assign bus.err       = err_s;
  assign bus.reqVA     = req_va_s;
  assign bus.reqVAPort = req_va_s ? port_r : '0;
  assign bus.reqVAVC   = req_va_s ? vc_mask_r : '0;
  assign bus.reqSA     = req_sa_s;
  assign bus.outPort   = out_port_r;
  assign bus.outVC     = out_vc_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_input_vc_controller_pipe.sv
// -----------------------------------------------------------------------------
// tb_input_vc_controller_pipe
// Directed, self-checking bench for input_vc_controller_pipe. Inputs change
// 1 ns after each rising edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_input_vc_controller_pipe;
  import noc_pkg::*;

  localparam int N    = 5;
  localparam int V    = 4;
  localparam int DW   = 34;
  localparam int DSTW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  input_vc_controller_pipe_if #(.N(N), .V(V), .DW(DW), .DSTW(DSTW)) bus ();

  input_vc_controller_pipe #(.N(N), .V(V), .DW(DW), .DSTW(DSTW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic [1:0] t, input logic [DSTW-1:0] d);
    flit = {t, {(DW-2-DSTW){1'b0}}, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] t, input logic [DSTW-1:0] d);
    bus.valid = v;
    bus.data  = flit(t, d);
  endtask

  task automatic va_hold_chk(input string tag);
    chk({tag, "_state"}, bus.state, 2'd1);
    chk({tag, "_reqVA"}, bus.reqVA, 1'b1);
    chk({tag, "_reqVAPort"}, bus.reqVAPort, 5'b01000);
    chk({tag, "_reqVAVC"}, bus.reqVAVC, 4'b0100);
    chk({tag, "_reqSA"}, bus.reqSA, 5'b00000);
    chk({tag, "_pop"}, bus.pop, 1'b0);
  endtask

  initial begin
    rstn            = 1'b0;
    bus.data        = '0;
    bus.valid       = 1'b0;
    bus.rcPort      = '0;
    bus.rcVC        = '0;
    bus.vaGrant     = 1'b0;
    bus.vaVC        = '0;
    bus.saGrant     = 1'b0;
    bus.readyVC_all = '0;

    // Reset state
    #12;
    chk("rst_state", bus.state, 2'd0);
    chk("rst_outputs", {bus.pop, bus.reqVA, bus.reqVAPort, bus.reqVAVC, bus.reqSA, bus.err}, 17'd0);
    chk("rst_outPort", bus.outPort, 5'd0);
    chk("rst_outVC", bus.outVC, 4'd0);
    rstn = 1'b1;

    // Idle with valid low for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_quiet", {bus.state, bus.pop, bus.reqVA, bus.reqSA, bus.err, bus.outPort, bus.outVC}, 18'd0);
    end

    // Packet HEAD,BODY,BODY,TAIL to port 2 VC1 with immediate grants
    step(); drv(1'b1, FLIT_HEAD, 8'h2A);
    bus.rcPort = 5'b00100; bus.rcVC = 4'b0011; bus.readyVC_all = 20'h00200;
    settle();
    chk("p1_t0_state", bus.state, 2'd0);
    chk("p1_t0_pop", bus.pop, 1'b0);
    chk("p1_t0_dst", bus.dst, 8'h2A);
    step(); bus.vaGrant = 1'b1; bus.vaVC = 4'b0010; settle();
    chk("p1_t1_state", bus.state, 2'd1);
    chk("p1_t1_reqVA", bus.reqVA, 1'b1);
    chk("p1_t1_reqVAPort", bus.reqVAPort, 5'b00100);
    chk("p1_t1_reqVAVC", bus.reqVAVC, 4'b0011);
    chk("p1_t1_reqSA", bus.reqSA, 5'b00000);
    step(); bus.vaGrant = 1'b0; bus.vaVC = 4'b0000; bus.saGrant = 1'b1; settle();
    chk("p1_t2_state", bus.state, 2'd2);
    chk("p1_t2_outPort", bus.outPort, 5'b00100);
    chk("p1_t2_outVC", bus.outVC, 4'b0010);
    chk("p1_t2_reqSA", bus.reqSA, 5'b00100);
    chk("p1_t2_pop", bus.pop, 1'b1);
    chk("p1_t2_err", bus.err, 1'b0);
    chk("p1_t2_reqVA", bus.reqVA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); drv(1'b1, (i == 2) ? FLIT_TAIL : FLIT_BODY, 8'h10 + 8'(i)); settle();
      chk("p1_stream_pop", bus.pop, 1'b1);
      chk("p1_stream_err", bus.err, 1'b0);
    end
    step(); drv(1'b0, FLIT_BODY, 8'h00); bus.saGrant = 1'b0; settle();
    chk("p1_t6_state", bus.state, 2'd0);
    chk("p1_t6_outPort", bus.outPort, 5'd0);
    chk("p1_t6_outVC", bus.outVC, 4'd0);

    // HEADTAIL then HEAD back to back
    step(); drv(1'b1, FLIT_HEADTAIL, 8'h33);
    bus.rcPort = 5'b00010; bus.rcVC = 4'b1000; bus.readyVC_all = 20'h00080;
    settle();
    chk("p2_t0_state", bus.state, 2'd0);
    step(); bus.vaGrant = 1'b1; bus.vaVC = 4'b1000; settle();
    chk("p2_t1_reqVAPort", bus.reqVAPort, 5'b00010);
    chk("p2_t1_reqVAVC", bus.reqVAVC, 4'b1000);
    step(); bus.vaGrant = 1'b0; bus.vaVC = 4'b0000; bus.saGrant = 1'b1; settle();
    chk("p2_t2_reqSA", bus.reqSA, 5'b00010);
    chk("p2_t2_pop", bus.pop, 1'b1);
    chk("p2_t2_outVC", bus.outVC, 4'b1000);
    chk("p2_t2_err", bus.err, 1'b0);
    step(); drv(1'b1, FLIT_HEAD, 8'h44); bus.rcPort = 5'b00001; bus.rcVC = 4'b0001; bus.saGrant = 1'b0; settle();
    chk("p2_t3_state", bus.state, 2'd0);
    chk("p2_t3_outPort", bus.outPort, 5'd0);
    chk("p2_t3_outVC", bus.outVC, 4'd0);
    chk("p2_t3_pop", bus.pop, 1'b0);
    step(); bus.vaGrant = 1'b1; bus.vaVC = 4'b0001; settle();
    chk("p2_t4_state", bus.state, 2'd1);
    chk("p2_t4_reqVAPort", bus.reqVAPort, 5'b00001);
    step(); bus.vaGrant = 1'b0; bus.vaVC = 4'b0000; bus.saGrant = 1'b1; bus.readyVC_all = 20'h00001; settle();
    chk("p2_t5_pop", bus.pop, 1'b1);
    chk("p2_t5_reqSA", bus.reqSA, 5'b00001);
    chk("p2_t5_err", bus.err, 1'b0);
    // A second HEAD inside the packet is an error but is still forwarded
    step(); drv(1'b1, FLIT_HEAD, 8'h45); settle();
    chk("p2_dup_head_pop", bus.pop, 1'b1);
    chk("p2_dup_head_err", bus.err, 1'b1);
    chk("p2_dup_head_state", bus.state, 2'd2);
    step(); drv(1'b1, FLIT_TAIL, 8'h46); settle();
    chk("p2_tail_pop", bus.pop, 1'b1);
    chk("p2_tail_err", bus.err, 1'b0);
    step(); drv(1'b0, FLIT_BODY, 8'h00); bus.saGrant = 1'b0; settle();
    chk("p2_end_state", bus.state, 2'd0);

    // Output VC not ready: saGrant ignored for 4 cycles
    step(); drv(1'b1, FLIT_HEAD, 8'h55);
    bus.rcPort = 5'b00100; bus.rcVC = 4'b0010; bus.readyVC_all = 20'h00000;
    settle();
    step(); bus.vaGrant = 1'b1; bus.vaVC = 4'b0010; settle();
    chk("p3_va_state", bus.state, 2'd1);
    step(); bus.vaGrant = 1'b0; bus.vaVC = 4'b0000; bus.saGrant = 1'b1; settle();
    chk("p3_stall_reqSA", bus.reqSA, 5'b00000);
    chk("p3_stall_pop", bus.pop, 1'b0);
    chk("p3_stall_state", bus.state, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("p3_stall_reqSA", bus.reqSA, 5'b00000);
      chk("p3_stall_pop", bus.pop, 1'b0);
      chk("p3_stall_state", bus.state, 2'd2);
    end
    step(); bus.readyVC_all = 20'h00200; settle();
    chk("p3_ready_reqSA", bus.reqSA, 5'b00100);
    chk("p3_ready_pop", bus.pop, 1'b1);
    step(); drv(1'b1, FLIT_TAIL, 8'h56); settle();
    chk("p3_tail_pop", bus.pop, 1'b1);
    step(); drv(1'b0, FLIT_BODY, 8'h00); bus.saGrant = 1'b0; settle();
    chk("p3_end_state", bus.state, 2'd0);

    // Orphan BODY in IDLE is dropped with an error pulse
    step(); drv(1'b1, FLIT_BODY, 8'h66); settle();
    chk("orphan_err", bus.err, 1'b1);
    chk("orphan_pop", bus.pop, 1'b1);
    chk("orphan_state", bus.state, 2'd0);
    step(); drv(1'b0, FLIT_BODY, 8'h00); settle();
    chk("orphan_after_state", bus.state, 2'd0);
    chk("orphan_after_err", bus.err, 1'b0);

    // VA grant withheld for 6 cycles
    step(); drv(1'b1, FLIT_HEAD, 8'h77); bus.rcPort = 5'b01000; bus.rcVC = 4'b0100; settle();
    step(); bus.saGrant = 1'b1; settle();
    va_hold_chk("va_hold");
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      va_hold_chk("va_hold");
    end
    step(); bus.vaGrant = 1'b1; bus.vaVC = 4'b0100; settle();
    chk("p4_grant_state", bus.state, 2'd1);
    step(); bus.vaGrant = 1'b0; bus.vaVC = 4'b0000; bus.readyVC_all = 20'h04000; settle();
    chk("p4_active_state", bus.state, 2'd2);
    chk("p4_active_reqSA", bus.reqSA, 5'b01000);
    chk("p4_active_pop", bus.pop, 1'b1);
    chk("p4_active_outVC", bus.outVC, 4'b0100);
    step(); drv(1'b1, FLIT_BODY, 8'h78); settle();
    chk("p4_body_pop", bus.pop, 1'b1);

    // Asynchronous reset mid-packet
    drv(1'b0, FLIT_BODY, 8'h00); bus.saGrant = 1'b0; rstn = 1'b0;
    #1;
    chk("arst_outPort", bus.outPort, 5'd0);
    chk("arst_outVC", bus.outVC, 4'd0);
    chk("arst_reqSA", bus.reqSA, 5'd0);
    chk("arst_state", bus.state, 2'd0);
    step(); rstn = 1'b1; drv(1'b1, FLIT_HEADTAIL, 8'h88); bus.rcPort = 5'b10000; bus.rcVC = 4'b0001; settle();
    chk("post_rst_state", bus.state, 2'd0);
    chk("post_rst_pop", bus.pop, 1'b0);
    step(); bus.vaGrant = 1'b1; bus.vaVC = 4'b0001; settle();
    chk("post_rst_va_state", bus.state, 2'd1);
    chk("post_rst_reqVAPort", bus.reqVAPort, 5'b10000);
    step(); bus.vaGrant = 1'b0; bus.vaVC = 4'b0000; bus.saGrant = 1'b1; bus.readyVC_all = 20'h10000; settle();
    chk("post_rst_outPort", bus.outPort, 5'b10000);
    chk("post_rst_reqSA", bus.reqSA, 5'b10000);
    chk("post_rst_pop", bus.pop, 1'b1);
    step(); drv(1'b0, FLIT_BODY, 8'h00); bus.saGrant = 1'b0; settle();
    chk("post_rst_end_state", bus.state, 2'd0);
    chk("post_rst_end_outPort", bus.outPort, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/input_vc_controller_pipe.md
Name: input_vc_controller_pipe

Overview:
Per-input-VC controller for the parametrised pipelined router. It sequences one virtual channel through routing latch, VC allocation and switch allocation, with VA and SA in separate cycles. It tracks the allocated output port/VC for the whole packet and generates the FIFO pop.
- One instance per input VC; N*V instances per router.
- Sits between the input FIFO, the RC unit, the VC allocator and the switch allocator.

Parameters:
N, 5, number of router ports
V, 4, number of VCs per port
DW, 34, flit width in bits
DSTW, 8, destination field width; dst = data[DSTW-1:0]

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
data  input  DW  flit at FIFO head
valid  input  1  FIFO not empty
pop  output  1  dequeue FIFO head this cycle
dst  output  DSTW  destination to RC unit
rcPort  input  N  RC result, one-hot
rcVC  input  V  permitted output VC mask, non-zero
reqVA  output  1  VC allocation request
reqVAPort  output  N  requested output port, one-hot
reqVAVC  output  V  requested output VC mask
vaGrant  input  1  VC allocation granted
vaVC  input  V  granted output VC, one-hot, subset of reqVAVC
reqSA  output  N  switch allocation request, one-hot or zero
saGrant  input  1  switch allocation granted
outPort  output  N  allocated output port (registered)
outVC  output  V  allocated output VC (registered)
readyVC_all  input  N*V  output VC ready, bit p*V+v = port p VC v
err  output  1  one-cycle pulse on protocol error
state  output  2  FSM state, for debug and coverage

Behaviour:
- Flit type field is data[DW-1:DW-2]: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL (single-flit packet).
- dst = data[DSTW-1:0], combinational, in all states.
- Reset: state=IDLE; outPort, outVC, portR, vcMaskR = 0. All outputs read 0 except dst.
- FSM states: IDLE=0, VA=1, ACTIVE=2; 3 is unused and recovers to IDLE.
- IDLE:
  - valid & type in {HEAD, HEADTAIL}: portR<=rcPort, vcMaskR<=rcVC, next state VA. No pop.
  - valid & type in {BODY, TAIL}: err=1 and pop=1, so the orphan flit is dropped; stay IDLE.
  - !valid: hold.
- VA:
  - reqVA=1, reqVAPort=portR, reqVAVC=vcMaskR; reqSA=0.
  - vaGrant: outPort<=portR, outVC<=vaVC, next state ACTIVE.
  - No vaGrant: stay in VA with the request held stable. There is no timeout.
- ACTIVE:
  - rdy = readyVC_all[idx(outPort)*V + idx(outVC)].
  - reqSA = outPort when valid & rdy, else 0.
  - pop = saGrant & |reqSA, combinational, same cycle as the grant.
  - saGrant while reqSA==0 is ignored (no pop, no state change).
  - Popped flit TAIL or HEADTAIL: next state IDLE; outPort and outVC cleared to 0.
  - Popped HEAD inside ACTIVE: err=1, flit still forwarded.
- Latency: head visible in IDLE at cycle t; reqVA at t+1; with immediate grants, reqSA at t+2 and pop at t+2. Body flits stream at 1 flit/cycle while rdy and grants persist.
- Back-to-back packets: after a tail pop at cycle t, the next head is latched at t+1.
- reqVA, reqVAPort and reqVAVC are 0 outside VA. reqSA is 0 outside ACTIVE.
- vaGrant outside VA and saGrant outside ACTIVE are ignored.
- Reset asserted mid-packet returns to IDLE immediately. Flits already in the FIFO are not the controller's responsibility.
- Index conversion of a one-hot value: zero or multi-hot input yields index 0. The bench asserts one-hot on rcPort and vaVC.

Decomposition:
- Package noc_pkg holds:
  - flit type constants (BODY/HEAD/TAIL/HEADTAIL) and the type-field position;
  - state encoding;
  - the default N, V, DW, DSTW.
- One sub-module, onehot_to_bin #(W): one-hot to $clog2(W)-bit index. It is instantiated twice, for outPort and outVC, and drives the readyVC_all select.

Test Plan:
- Reset, then idle with valid=0 -> all outputs 0, state=0 for 10 cycles.
- HEAD rcPort=5'b00100, rcVC=4'b0011, vaGrant at t+1 with vaVC=4'b0010, rdy bit 2*4+1=9 high, saGrant at t+2 -> reqSA=5'b00100 and pop at t+2. Then BODY, BODY, TAIL pop at t+3..t+5; state=IDLE at t+6.
- HEADTAIL then HEAD on consecutive FIFO entries, all grants immediate -> pops at t+2 and t+5; outPort cleared at t+3.
- ACTIVE with readyVC_all bit 9 low for 4 cycles -> reqSA=0 and no pop despite saGrant=1. Bit high -> reqSA asserts the same cycle.
- BODY flit in IDLE -> err=1, pop=1 for one cycle, state stays 0. vaGrant withheld 6 cycles in VA -> reqVA stable, no reqSA.
- rstn low while in ACTIVE mid-packet -> outPort=0, outVC=0, reqSA=0 asynchronously. A fresh HEAD after release is processed normally.
